// File: rtl/pixspi_tx_pkg.sv
// Shared definitions for the pixel SPI link: FSM states, default widths and SPI mode 0 line levels.
package pixspi_tx_pkg;
  localparam int   DEF_ADDR_W  = 12;
  localparam int   DEF_DATA_W  = 32;
  localparam logic SPI_CPOL    = 1'b0;  // mode 0: clock idles low, data sampled on rise
  localparam logic SPI_SS_IDLE = 1'b1;

  typedef enum logic [2:0] {
    IDLE, SETUP, FETCH, LOAD, SHIFT, HOLD, GAP
  } state_t;
endpackage

// File: rtl/pixspi_tx_halfper.sv
// SPI half-period divider: ticks on the last sysclk of each CLK_DIV-cycle half, low half first after clr.
// Count freezes while en is low; clr restarts at the beginning of a low half.
module pixspi_tx_halfper #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  output logic tick_lo_end,
  output logic tick_hi_end
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             phase_hi;
  logic             half_end;

  assign half_end = en && (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (clr) begin
      div_cnt  <= '0;
      phase_hi <= 1'b0;
    end else if (half_end) begin
      div_cnt  <= '0;
      phase_hi <= !phase_hi;
    end else if (en) begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick_lo_end = half_end && !phase_hi;
  assign tick_hi_end = half_end && phase_hi;
endmodule

// File: rtl/pixspi_tx.sv
// Pixel frame SPI master (mode 0, MSB first): one start sends NUM_WORDS RAM words from address 0.
// Word time 2+2*DATA_W*CLK_DIV cycles; start is dropped while busy or while done is high.
module pixspi_tx
  import pixspi_tx_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_WORDS = 4096,
  parameter int CLK_DIV   = 2
) (
  input  logic              sysclk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] rdata,
  output logic              spi_clk,
  output logic              spi_ss,
  output logic              spi_mosi
);
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);
  localparam logic [ADDR_W:0]  WORD_LAST = (ADDR_W + 1)'(NUM_WORDS - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg;
  logic [BIT_W-1:0]  bit_cnt;
  logic [ADDR_W:0]   word_cnt;
  logic              tick_lo_end, tick_hi_end;
  logic              hp_en, hp_clr;
  logic              last_bit, last_word;

  assign last_bit  = (bit_cnt == BIT_LAST);
  assign last_word = (word_cnt == WORD_LAST);

  // SETUP/HOLD reuse the low-half tick and GAP the high-half tick, so one divider times every phase.
  assign hp_en  = state_q inside {SETUP, SHIFT, HOLD, GAP};
  assign hp_clr = rst || (state_q == LOAD);

  pixspi_tx_halfper #(.CLK_DIV(CLK_DIV)) u_halfper (
    .clk        (sysclk),
    .clr        (hp_clr),
    .en         (hp_en),
    .tick_lo_end(tick_lo_end),
    .tick_hi_end(tick_hi_end)
  );

  always_ff @(posedge sysclk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && !done) state_d = SETUP;
      SETUP:   if (tick_lo_end) state_d = FETCH;
      FETCH:   state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT:   if (tick_hi_end && last_bit) state_d = last_word ? HOLD : FETCH;
      HOLD:    if (tick_lo_end) state_d = GAP;
      GAP:     if (tick_hi_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      raddr    <= '0;
      word_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      spi_clk  <= SPI_CPOL;
      spi_ss   <= SPI_SS_IDLE;
      spi_mosi <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: if (start && !done) begin
          spi_ss   <= !SPI_SS_IDLE;
          busy     <= 1'b1;
          raddr    <= '0;
          word_cnt <= '0;
        end
        LOAD: begin
          shreg    <= rdata;
          bit_cnt  <= '0;
          spi_mosi <= rdata[DATA_W-1];
        end
        SHIFT: begin
          if (tick_lo_end) spi_clk <= !SPI_CPOL;
          if (tick_hi_end) begin
            spi_clk <= SPI_CPOL;
            shreg   <= shreg << 1;
            bit_cnt <= bit_cnt + 1'b1;
            // Next bit goes out on the same edge that ends this bit's high half.
            if (!last_bit) begin
              spi_mosi <= shreg[DATA_W-2];
            end else if (!last_word) begin
              raddr    <= raddr + 1'b1;
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        HOLD: if (tick_lo_end) spi_ss <= SPI_SS_IDLE;
        GAP: if (tick_hi_end) begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pixspi_tx.sv
// Directed bench for pixspi_tx: three instances share sysclk (2-word frame, 64-word loopback, slow divider).
module tb_pixspi_tx;
  logic sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  int vectors     = 0;
  int miscompares = 0;

  // Instance A: DATA_W=32, CLK_DIV=2, NUM_WORDS=2
  logic        a_rst, a_start, a_busy, a_done, a_sclk, a_ss, a_mosi;
  logic [11:0] a_raddr;
  logic [31:0] a_rdata;
  logic [31:0] a_mem [4];
  pixspi_tx #(.ADDR_W(12), .DATA_W(32), .NUM_WORDS(2), .CLK_DIV(2)) u_a (
    .sysclk(sysclk), .rst(a_rst), .start(a_start), .busy(a_busy), .done(a_done),
    .raddr(a_raddr), .rdata(a_rdata), .spi_clk(a_sclk), .spi_ss(a_ss), .spi_mosi(a_mosi));
  always @(posedge sysclk) a_rdata <= a_mem[a_raddr[1:0]];

  // Instance B: full 2**ADDR_W frame for the loopback receiver
  logic        b_rst, b_start, b_busy, b_done, b_sclk, b_ss, b_mosi;
  logic [5:0]  b_raddr;
  logic [31:0] b_rdata;
  logic [31:0] b_mem [64];
  pixspi_tx #(.ADDR_W(6), .DATA_W(32), .NUM_WORDS(64), .CLK_DIV(2)) u_b (
    .sysclk(sysclk), .rst(b_rst), .start(b_start), .busy(b_busy), .done(b_done),
    .raddr(b_raddr), .rdata(b_rdata), .spi_clk(b_sclk), .spi_ss(b_ss), .spi_mosi(b_mosi));
  always @(posedge sysclk) b_rdata <= b_mem[b_raddr];

  // Instance C: DATA_W=8, CLK_DIV=5
  logic        c_rst, c_start, c_busy, c_done, c_sclk, c_ss, c_mosi;
  logic [0:0]  c_raddr;
  logic [7:0]  c_rdata;
  logic [7:0]  c_mem [2];
  pixspi_tx #(.ADDR_W(1), .DATA_W(8), .NUM_WORDS(2), .CLK_DIV(5)) u_c (
    .sysclk(sysclk), .rst(c_rst), .start(c_start), .busy(c_busy), .done(c_done),
    .raddr(c_raddr), .rdata(c_rdata), .spi_clk(c_sclk), .spi_ss(c_ss), .spi_mosi(c_mosi));
  always @(posedge sysclk) c_rdata <= c_mem[c_raddr];

  // Pulses start on A and records what the SPI pins did over the next 600 cycles.
  task automatic run_frame_a(output int ss_low, output int rises, output int dn,
                             output int dn_delay, output logic [63:0] bits, output int rmax);
    logic prev_clk = 1'b0;
    int   ss_rise_at = -1;
    ss_low = 0; rises = 0; dn = 0; dn_delay = -1; bits = '0; rmax = 0;
    a_start = 1'b1;
    @(negedge sysclk);
    a_start = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (a_ss === 1'b0) ss_low++;
      else if (ss_low > 0 && ss_rise_at < 0) ss_rise_at = n;
      if (a_sclk === 1'b1 && prev_clk === 1'b0) begin
        rises++;
        bits = {bits[62:0], a_mosi};
      end
      prev_clk = a_sclk;
      if (int'(a_raddr) > rmax) rmax = int'(a_raddr);
      if (a_done === 1'b1) begin
        dn++;
        if (ss_rise_at >= 0) dn_delay = n - ss_rise_at;
      end
      @(negedge sysclk);
    end
  endtask

  task automatic test_reset();
    logic idle_bad = 1'b0;
    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
    a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
    repeat (3) @(negedge sysclk);
    vectors++; if (a_ss !== 1'b1)   begin miscompares++; $display("FAIL reset_ss: got %b want 1", a_ss); end
    vectors++; if (a_sclk !== 1'b0) begin miscompares++; $display("FAIL reset_sclk: got %b want 0", a_sclk); end
    vectors++; if (a_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", a_busy); end
    vectors++; if (a_done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", a_done); end
    vectors++; if (a_raddr !== 12'h000) begin miscompares++; $display("FAIL reset_raddr: got %h want 000", a_raddr); end
    vectors++; if (b_ss !== 1'b1 || c_ss !== 1'b1 || c_sclk !== 1'b0) begin
      miscompares++; $display("FAIL reset_bc: got ss %b/%b sclk %b want 1/1 0", b_ss, c_ss, c_sclk);
    end
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sysclk);
      if (a_sclk !== 1'b0 || a_ss !== 1'b1 || a_busy !== 1'b0) idle_bad = 1'b1;
    end
    vectors++; if (idle_bad !== 1'b0) begin miscompares++; $display("FAIL idle_quiet: got activity=%b want 0", idle_bad); end
  endtask

  task automatic test_basic_frame();
    int ss_low, rises, dn, dn_delay, rmax;
    logic [63:0] bits;
    run_frame_a(ss_low, rises, dn, dn_delay, bits, rmax);
    vectors++; if (ss_low !== 264) begin miscompares++; $display("FAIL basic_ss_low: got %0d want 264", ss_low); end
    vectors++; if (rises !== 64)   begin miscompares++; $display("FAIL basic_rises: got %0d want 64", rises); end
    vectors++; if (bits[63:32] !== 32'hDEADBEEF) begin miscompares++; $display("FAIL basic_word0: got %h want deadbeef", bits[63:32]); end
    vectors++; if (bits[31:0] !== 32'h12345678)  begin miscompares++; $display("FAIL basic_word1: got %h want 12345678", bits[31:0]); end
    vectors++; if (dn !== 1)       begin miscompares++; $display("FAIL basic_done_cnt: got %0d want 1", dn); end
    vectors++; if (dn_delay !== 2) begin miscompares++; $display("FAIL basic_done_delay: got %0d want 2", dn_delay); end
    vectors++; if (rmax !== 1)     begin miscompares++; $display("FAIL basic_raddr_max: got %0d want 1", rmax); end
  endtask

  task automatic test_back_to_back();
    int   dn = 0, hi_run = 0, min_gap = 1000;
    logic had_low = 1'b0, prev_done = 1'b0, drop_bad = 1'b0, drained = 1'b0, extra = 1'b0;
    a_start = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      @(negedge sysclk);
      if (a_done === 1'b1) dn++;
      if (prev_done && a_busy !== 1'b0) drop_bad = 1'b1;
      prev_done = a_done;
      if (a_ss === 1'b1) hi_run++;
      else begin
        if (had_low && hi_run > 0 && hi_run < min_gap) min_gap = hi_run;
        hi_run = 0;
        had_low = 1'b1;
      end
    end
    a_start = 1'b0;
    vectors++; if (dn !== 3) begin miscompares++; $display("FAIL b2b_frames: got %0d want 3", dn); end
    vectors++; if (!(min_gap >= 3 && min_gap < 1000)) begin miscompares++; $display("FAIL b2b_gap: got %0d want >=3", min_gap); end
    vectors++; if (drop_bad !== 1'b0) begin miscompares++; $display("FAIL b2b_start_on_done: got busy after done=%b want 0", drop_bad); end
    for (int k = 0; k < 600 && !drained; k++) begin
      @(negedge sysclk);
      if (a_done === 1'b1) drained = 1'b1;
    end
    vectors++; if (drained !== 1'b1) begin miscompares++; $display("FAIL b2b_drain: got timeout want done"); end
    for (int k = 0; k < 20; k++) begin
      @(negedge sysclk);
      if (a_ss !== 1'b1 || a_busy !== 1'b0) extra = 1'b1;
    end
    vectors++; if (extra !== 1'b0) begin miscompares++; $display("FAIL b2b_no_extra: got activity=%b want 0", extra); end
  endtask

  task automatic test_reset_mid_frame();
    int   ss_low, rises, dn, dn_delay, rmax;
    logic [63:0] bits;
    logic bad = 1'b0;
    a_start = 1'b1;
    @(negedge sysclk);
    a_start = 1'b0;
    repeat (100) @(negedge sysclk);
    a_rst = 1'b1;
    @(negedge sysclk);
    a_rst = 1'b0;
    vectors++; if (a_ss !== 1'b1 || a_busy !== 1'b0 || a_sclk !== 1'b0) begin
      miscompares++; $display("FAIL midrst_outputs: got ss=%b busy=%b sclk=%b want 1 0 0", a_ss, a_busy, a_sclk);
    end
    for (int k = 0; k < 300; k++) begin
      @(negedge sysclk);
      if (a_done !== 1'b0 || a_ss !== 1'b1) bad = 1'b1;
    end
    vectors++; if (bad !== 1'b0) begin miscompares++; $display("FAIL midrst_no_done: got activity=%b want 0", bad); end
    run_frame_a(ss_low, rises, dn, dn_delay, bits, rmax);
    vectors++; if (ss_low !== 264 || dn !== 1) begin
      miscompares++; $display("FAIL midrst_refresh: got ss_low=%0d done=%0d want 264 1", ss_low, dn);
    end
    vectors++; if (bits !== 64'hDEADBEEF_12345678) begin miscompares++; $display("FAIL midrst_data: got %h want deadbeef12345678", bits); end
  endtask

  task automatic test_loopback();
    logic [31:0] sh = '0;
    int   nb = 0, nw = 0, bad_data = 0, addr = 0, rmax = 0;
    logic prev = 1'b0, prev_ss = 1'b1, fin = 1'b0;
    b_start = 1'b1;
    @(negedge sysclk);
    b_start = 1'b0;
    for (int n = 0; n < 9000 && !fin; n++) begin
      if (prev_ss === 1'b1 && b_ss === 1'b0) begin addr = 0; nb = 0; end
      if (b_ss === 1'b0 && b_sclk === 1'b1 && prev === 1'b0) begin
        sh = {sh[30:0], b_mosi};
        nb++;
        if (nb == 32) begin
          if (addr >= 64 || sh !== b_mem[addr]) bad_data++;
          addr++; nw++; nb = 0;
        end
      end
      prev = b_sclk; prev_ss = b_ss;
      if (int'(b_raddr) > rmax) rmax = int'(b_raddr);
      if (b_done === 1'b1) fin = 1'b1;
      @(negedge sysclk);
    end
    vectors++; if (fin !== 1'b1)  begin miscompares++; $display("FAIL loop_done: got timeout want done"); end
    vectors++; if (nw !== 64)     begin miscompares++; $display("FAIL loop_words: got %0d want 64", nw); end
    vectors++; if (bad_data !== 0) begin miscompares++; $display("FAIL loop_data: got %0d bad words want 0", bad_data); end
    vectors++; if (nb !== 0)      begin miscompares++; $display("FAIL loop_partial: got %0d stray bits want 0", nb); end
    vectors++; if (rmax !== 63)   begin miscompares++; $display("FAIL loop_raddr_max: got %0d want 63", rmax); end
  endtask

  task automatic test_slow_div();
    logic [15:0] bits = '0;
    int   rises = 0, held = 0, min_held = 1000, last_rise = -1, int10 = 0, int12 = 0;
    logic prev_clk = 1'b0, prev_mosi = 1'b0, fin = 1'b0;
    c_start = 1'b1;
    @(negedge sysclk);
    c_start = 1'b0;
    for (int n = 0; n < 600 && !fin; n++) begin
      if (c_mosi !== prev_mosi) held = 0;
      if (c_sclk === 1'b1 && prev_clk === 1'b0) begin
        rises++;
        bits = {bits[14:0], c_mosi};
        if (held < min_held) min_held = held;
        if (last_rise >= 0 && n - last_rise == 10) int10++;
        if (last_rise >= 0 && n - last_rise == 12) int12++;
        last_rise = n;
      end
      held++;
      prev_clk = c_sclk; prev_mosi = c_mosi;
      if (c_done === 1'b1) fin = 1'b1;
      @(negedge sysclk);
    end
    vectors++; if (fin !== 1'b1)   begin miscompares++; $display("FAIL slow_done: got timeout want done"); end
    vectors++; if (rises !== 16)   begin miscompares++; $display("FAIL slow_rises: got %0d want 16", rises); end
    vectors++; if (bits !== 16'hA53C) begin miscompares++; $display("FAIL slow_data: got %h want a53c", bits); end
    vectors++; if (min_held < 5)   begin miscompares++; $display("FAIL slow_setup: got %0d cycles want >=5", min_held); end
    vectors++; if (int10 !== 14 || int12 !== 1) begin
      miscompares++; $display("FAIL slow_bit_period: got %0d x10 %0d x12 want 14 1", int10, int12);
    end
  endtask

  initial begin
    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
    a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
    a_mem[0] = 32'hDEADBEEF; a_mem[1] = 32'h12345678; a_mem[2] = '0; a_mem[3] = '0;
    for (int i = 0; i < 64; i++) b_mem[i] = (32'h9E3779B9 * 32'(i + 1)) ^ 32'(i);
    c_mem[0] = 8'hA5; c_mem[1] = 8'h3C;
    test_reset();
    test_basic_frame();
    test_back_to_back();
    test_reset_mid_frame();
    test_loopback();
    test_slow_div();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
